// File: rtl/aes_pkg.sv
// Shared AES-256 key schedule types, constants and S-box helpers.
// The S-box is computed as GF(2^8) inversion followed by the affine map.
package aes_pkg;

    typedef logic [0:127] rk_t;
    typedef logic [0:255] key256_t;

    localparam int AES256_NUM_RK    = 15;
    localparam int AES256_EXP_ITERS = 7;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

endpackage

// File: rtl/key_sched_store.sv
// Round-key register file: one dual-half 256-bit write port, one registered read port.
// Out-of-range reads return zero with valid still asserted.
module key_sched_store
    import aes_pkg::*;
#(
    parameter int num_rk_p = AES256_NUM_RK
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr_en,
    input  logic         i_wr_hi_en,
    input  logic [3:0]   i_wr_idx,
    input  logic [0:255] i_wr_data,
    input  logic         i_rd_en,
    input  logic [3:0]   i_rd_idx,
    output logic         o_rd_v,
    output logic [0:127] o_rd_data
);

    localparam logic [3:0] LAST_IDX = 4'(num_rk_p - 1);

    rk_t         r_mem [num_rk_p];
    logic        r_rd_v;
    rk_t         r_rd_data;
    logic [3:0]  w_hi_idx;

    assign w_hi_idx  = i_wr_idx + 4'd1;
    assign o_rd_v    = r_rd_v;
    assign o_rd_data = r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            if (i_wr_idx <= LAST_IDX) begin
                r_mem[i_wr_idx] <= i_wr_data[0:127];
            end
            if (i_wr_hi_en && (w_hi_idx <= LAST_IDX)) begin
                r_mem[w_hi_idx] <= i_wr_data[128:255];
            end
        end
    end

    // Read data holds its last value when no request is accepted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_v    <= 1'b0;
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_v    <= 1'b1;
            r_rd_data <= (i_rd_idx <= LAST_IDX) ? r_mem[i_rd_idx] : '0;
        end else begin
            r_rd_v    <= 1'b0;
        end
    end

endmodule

// File: rtl/round_key.sv
// One AES-256 key expansion iteration: eight words in, the next eight words out.
// Round constant is derived from the iteration number i_r (1..7).
module round_key
    import aes_pkg::*;
(
    input  logic [0:255] i_w,
    input  logic [3:0]   i_r,
    output logic [0:255] o_next
);

    logic [31:0] w_in  [8];
    logic [31:0] w_out [8];
    logic [7:0]  w_rcon;

    always_comb begin
        o_next = '0;
        case (i_r)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            default: w_rcon = 8'h00;
        endcase
        for (int j = 0; j < 8; j++) begin
            w_in[j] = i_w[32*j +: 32];
        end
        // Word 0 uses RotWord+SubWord+Rcon; word 4 gets the extra AES-256 SubWord.
        w_out[0] = w_in[0] ^ sub_word({w_in[7][23:0], w_in[7][31:24]}) ^ {w_rcon, 24'h000000};
        for (int j = 1; j < 4; j++) begin
            w_out[j] = w_in[j] ^ w_out[j-1];
        end
        w_out[4] = w_in[4] ^ sub_word(w_out[3]);
        for (int j = 5; j < 8; j++) begin
            w_out[j] = w_in[j] ^ w_out[j-1];
        end
        for (int j = 0; j < 8; j++) begin
            o_next[32*j +: 32] = w_out[j];
        end
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-256 key expansion sequencer serving 15 round keys over an indexed read handshake.
// Build macro KEY_SCHED_EARLY_READ_EN: accept reads of already-written keys while expanding.
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int num_rk_p    = AES256_NUM_RK,
    parameter int idx_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   key_v_i,
    input  logic [0:255]           key_i,
    output logic                   key_ready_o,
    output logic                   done_o,
    input  logic                   rk_req_v_i,
    input  logic [idx_width_p-1:0] rk_idx_i,
    output logic                   rk_req_ready_o,
    output logic                   rk_v_o,
    output logic [0:127]           rk_o
);

    localparam logic [3:0] LAST_ITER = 4'(AES256_EXP_ITERS);

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_round;
    logic [3:0]   w_round_next;
    key256_t      r_work;
    key256_t      w_work_next;
    logic [0:255] w_rk_next;
    logic         w_key_accept;
    logic         w_rd_accept;
    logic         w_wr_en;
    logic         w_wr_hi_en;
    logic [3:0]   w_wr_idx;
    logic [0:255] w_wr_data;

    assign key_ready_o  = (r_state != EXPAND);
    assign done_o       = (r_state == DONE);
    assign w_key_accept = key_v_i & key_ready_o;
    assign w_rd_accept  = rk_req_v_i & rk_req_ready_o;

`ifdef KEY_SCHED_EARLY_READ_EN
    logic [idx_width_p-1:0] w_written_cnt;

    // At iteration r, keys 0..2r-1 are already in the store.
    assign w_written_cnt  = idx_width_p'({r_round[2:0], 1'b0});
    assign rk_req_ready_o = done_o | ((r_state == EXPAND) && (rk_idx_i < w_written_cnt));
`else
    assign rk_req_ready_o = done_o;
`endif

    round_key u_round_key (
        .i_w    (r_work),
        .i_r    (r_round),
        .o_next (w_rk_next)
    );

    key_sched_store #(
        .num_rk_p (num_rk_p)
    ) u_store (
        .i_clk     (clk_i),
        .i_reset   (reset_i),
        .i_wr_en   (w_wr_en),
        .i_wr_hi_en(w_wr_hi_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_accept),
        .i_rd_idx  (4'(rk_idx_i)),
        .o_rd_v    (rk_v_o),
        .o_rd_data (rk_o)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_round <= 4'd0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_next;
            r_round <= w_round_next;
            r_work  <= w_work_next;
        end
    end

    // Accept writes keys 0/1; each iteration r writes 2r/2r+1, dropping the unused upper half at r=7.
    always_comb begin
        w_state_next = r_state;
        w_round_next = r_round;
        w_work_next  = r_work;
        w_wr_en      = 1'b0;
        w_wr_hi_en   = 1'b0;
        w_wr_idx     = 4'd0;
        w_wr_data    = key_i;
        if (w_key_accept) begin
            w_state_next = EXPAND;
            w_round_next = 4'd1;
            w_work_next  = key_i;
            w_wr_en      = 1'b1;
            w_wr_hi_en   = 1'b1;
        end else if (r_state == EXPAND) begin
            w_work_next = w_rk_next;
            w_wr_en     = 1'b1;
            w_wr_hi_en  = (r_round < LAST_ITER);
            w_wr_idx    = {r_round[2:0], 1'b0};
            w_wr_data   = w_rk_next;
            if (r_round == LAST_ITER) begin
                w_state_next = DONE;
                w_round_next = 4'd0;
            end else begin
                w_round_next = r_round + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a table-driven FIPS-197 key expansion model.
module tb_key_schedule_ctrl;

   logic         clk;
   logic         reset;
   logic         key_v;
   logic [0:255] key;
   logic         key_ready;
   logic         done;
   logic         rk_req_v;
   logic [3:0]   rk_idx;
   logic         rk_req_ready;
   logic         rk_v;
   logic [0:127] rk;

   int n_checks;
   int n_fail;

   logic [0:2047] sbox_tab;
   logic [127:0]  exp_rk [15];

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] rk;
   } vec_t;
   vec_t vecs [5];

   key_schedule_ctrl dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .key_v_i       (key_v),
      .key_i         (key),
      .key_ready_o   (key_ready),
      .done_o        (done),
      .rk_req_v_i    (rk_req_v),
      .rk_idx_i      (rk_idx),
      .rk_req_ready_o(rk_req_ready),
      .rk_v_o        (rk_v),
      .rk_o          (rk)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if something never terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [7:0] sb(input logic [7:0] x);
      return sbox_tab[8*x +: 8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] v);
      return {sb(v[31:24]), sb(v[23:16]), sb(v[15:8]), sb(v[7:0])};
   endfunction

   // FIPS-197 word-by-word expansion, grouped into 128-bit round keys.
   task automatic modelExpand(input logic [0:255] k);
      logic [31:0] wd [60];
      logic [31:0] t;
      for (int i = 0; i < 8; i++) wd[i] = k[32*i +: 32];
      for (int i = 8; i < 60; i++) begin
         t = wd[i-1];
         if (i % 8 == 0)
            t = subw({t[23:0], t[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h000000};
         else if (i % 8 == 4)
            t = subw(t);
         wd[i] = wd[i-8] ^ t;
      end
      for (int n = 0; n < 15; n++) exp_rk[n] = {wd[4*n], wd[4*n+1], wd[4*n+2], wd[4*n+3]};
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic kv, input logic [0:255] k, input logic rv, input logic [3:0] idx);
      key_v    = kv;
      key      = k;
      rk_req_v = rv;
      rk_idx   = idx;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called right after the accept edge; we are then in expansion cycle 1.
   task automatic waitDone(input string name);
      int cnt;
      cnt = 1;
      while (!done && cnt < 20) begin
         tick;
         cnt++;
      end
      checkOutput(name, 128'(cnt), 128'd8);
   endtask

   task automatic loadKey(input logic [0:255] k, input string name);
      applyStimulus(1'b1, k, 1'b0, 4'd0);
      tick;
      checkOutput({name, " key_ready low"}, 128'(key_ready), 128'd0);
      checkOutput({name, " done low"}, 128'(done), 128'd0);
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      modelExpand(k);
      waitDone({name, " done latency"});
   endtask

   task automatic readCheck(input logic [3:0] idx, input string name);
      applyStimulus(1'b0, '0, 1'b1, idx);
      tick;
      checkOutput({name, " rk_v"}, 128'(rk_v), 128'd1);
      checkOutput({name, " rk"}, rk, (idx < 15) ? exp_rk[idx] : 128'd0);
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
   endtask

   function automatic logic [0:255] randKey();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      logic [0:255] keyC3;
      logic [0:255] k;
      logic [127:0] oldRk14;
      logic [127:0] lastRk;
      logic         reqV;
      logic [3:0]   reqIdx;
      int           cyc;
      int           expCycle;

      sbox_tab = {
         128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      keyC3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      vecs[0] = '{4'd15, 128'd0};
      vecs[1] = '{4'd0,  128'h000102030405060708090a0b0c0d0e0f};
      vecs[2] = '{4'd1,  128'h101112131415161718191a1b1c1d1e1f};
      vecs[3] = '{4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
      vecs[4] = '{4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
      n_checks = 0;
      n_fail   = 0;

      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      tick;
      tick;
      reset = 1'b0;
      checkOutput("reset key_ready", 128'(key_ready), 128'd1);
      checkOutput("reset done", 128'(done), 128'd0);
      checkOutput("reset rk_v", 128'(rk_v), 128'd0);
      checkOutput("reset rk_o", rk, 128'd0);
      checkOutput("reset req_ready", 128'(rk_req_ready), 128'd0);

      $display("[TB] FIPS-197 C.3 key expansion");
      loadKey(keyC3, "c3");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, '0, 1'b1, vecs[i].idx);
         checkOutput($sformatf("vec%0d req_ready", i), 128'(rk_req_ready), 128'd1);
         tick;
         checkOutput($sformatf("vec%0d rk_v", i), 128'(rk_v), 128'd1);
         checkOutput($sformatf("vec%0d rk idx %0d", i, vecs[i].idx), rk, vecs[i].rk);
      end
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      tick;
      checkOutput("idle rk_v", 128'(rk_v), 128'd0);
      checkOutput("idle rk hold", rk, vecs[4].rk);

      $display("[TB] back-to-back reads 0..14");
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 4'(i));
         tick;
         checkOutput($sformatf("b2b rk_v %0d", i), 128'(rk_v), 128'd1);
         checkOutput($sformatf("b2b rk %0d", i), rk, exp_rk[i]);
      end
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      tick;
      checkOutput("b2b end rk_v", 128'(rk_v), 128'd0);
      checkOutput("b2b end rk hold", rk, exp_rk[14]);

      $display("[TB] key accept and read in the same DONE cycle");
      oldRk14 = exp_rk[14];
      k = randKey();
      applyStimulus(1'b1, k, 1'b1, 4'd14);
      tick;
      checkOutput("overlap rk_v", 128'(rk_v), 128'd1);
      checkOutput("overlap old rk14", rk, oldRk14);
      checkOutput("overlap done dropped", 128'(done), 128'd0);
      checkOutput("overlap key_ready", 128'(key_ready), 128'd0);
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      modelExpand(k);
      waitDone("overlap done latency");
      readCheck(4'd14, "overlap new rk14");

      $display("[TB] reset during expansion");
      applyStimulus(1'b1, randKey(), 1'b0, 4'd0);
      tick;
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      tick;
      tick;
      tick;
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b1, 4'd0);
      tick;
      reset = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      checkOutput("midreset done", 128'(done), 128'd0);
      checkOutput("midreset key_ready", 128'(key_ready), 128'd1);
      checkOutput("midreset rk_v", 128'(rk_v), 128'd0);
      checkOutput("midreset rk_o", rk, 128'd0);
      checkOutput("midreset req_ready", 128'(rk_req_ready), 128'd0);
      loadKey(randKey(), "reload");
      for (int i = 0; i < 15; i++) readCheck(4'(i), $sformatf("reload rk %0d", i));

      $display("[TB] read of idx 3 one cycle after accept");
      applyStimulus(1'b1, randKey(), 1'b0, 4'd0);
      modelExpand(key);
      tick;
      applyStimulus(1'b0, '0, 1'b1, 4'd3);
      expCycle = 8;
`ifdef KEY_SCHED_EARLY_READ_EN
      for (int c = 1; c < 8; c++) begin
         if (2 * c > 3) begin
            expCycle = c;
            break;
         end
      end
`endif
      cyc = 1;
      while (!rk_req_ready && cyc < 20) begin
         tick;
         cyc++;
      end
      checkOutput("early read accept cycle", 128'(cyc), 128'(expCycle));
      tick;
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
      checkOutput("early read rk_v", 128'(rk_v), 128'd1);
      checkOutput("early read rk3", rk, exp_rk[3]);
      cyc = 0;
      while (!done && cyc < 20) begin
         tick;
         cyc++;
      end
      checkOutput("early read done", 128'(done), 128'd1);

      $display("[TB] randomized reads in DONE");
      lastRk = exp_rk[3];
      for (int i = 0; i < 40; i++) begin
         reqV   = 1'($urandom_range(0, 1));
         reqIdx = 4'($urandom_range(0, 15));
         applyStimulus(1'b0, '0, reqV, reqIdx);
         checkOutput($sformatf("rand req_ready %0d", i), 128'(rk_req_ready), 128'd1);
         tick;
         if (reqV) lastRk = (reqIdx < 15) ? exp_rk[reqIdx] : 128'd0;
         checkOutput($sformatf("rand rk_v %0d", i), 128'(rk_v), 128'(reqV));
         checkOutput($sformatf("rand rk %0d idx %0d", i, reqIdx), rk, lastRk);
      end
      applyStimulus(1'b0, '0, 1'b0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
